// File: rtl/apb_master_bridge.sv
// Purpose : APB requester; turns single-word host commands into one APB transfer each.
// Latency : write = 3 cycles (IDLE, SETUP, ACCESS), read with registered prdata = 4, plus wait states.
// Backpres: cmd_ready_o is high only in IDLE; the slave stalls ACCESS through pready_i, bounded by TIMEOUT.
//
// Ports
//   pclk_i, preset_ni           clock (rising edge) and synchronous active-low reset
//   cmd_valid_i / cmd_ready_o   command handshake; cmd_write_i, cmd_addr_i, cmd_wdata_i are the payload
//   rsp_valid_o                 one-cycle pulse per finished transfer
//   rsp_rdata_o, rsp_error_o    response payload, held until the next response
//   psel_o, penable_o, pwrite_o,
//   paddr_o, pwdata_o           APB requester outputs
//   prdata_i, pready_i          APB completer inputs
module apb_master_bridge #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int READ_LAT   = 1,
  parameter int TIMEOUT    = 16
) (
  input  logic                  pclk_i,
  input  logic                  preset_ni,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_write_i,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [DATA_WIDTH-1:0] cmd_wdata_i,
  output logic                  rsp_valid_o,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                  rsp_error_o,
  output logic                  psel_o,
  output logic                  penable_o,
  output logic                  pwrite_o,
  output logic [ADDR_WIDTH-1:0] paddr_o,
  output logic [DATA_WIDTH-1:0] pwdata_o,
  input  logic [DATA_WIDTH-1:0] prdata_i,
  input  logic                  pready_i
);

  // Wait counter is wide enough to hold TIMEOUT itself so it can saturate
  // without ever wrapping back to zero.
  localparam int            CW       = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_SAT  = CW'(TIMEOUT);
  // The completer registers prdata: read data appears one cycle after the
  // ACCESS completion edge, so reads detour through RDWAIT.
  localparam bit            RD_REG   = (READ_LAT != 0);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RDWAIT = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;

  logic [ADDR_WIDTH-1:0] r_paddr;
  logic [DATA_WIDTH-1:0] r_pwdata;
  logic                  r_pwrite;
  logic [CW-1:0]         r_cnt;
  logic                  r_rsp_valid;
  logic [DATA_WIDTH-1:0] r_rsp_rdata;
  logic                  r_rsp_error;

  logic                  w_idle;
  logic                  w_accept;
  logic                  w_cnt_clr;
  logic                  w_cnt_inc;
  logic                  w_rsp_set;
  logic                  w_rsp_err;
  logic                  w_rsp_load;

  // ------------------------------------------------------------------
  // Next-state and control decode
  // ------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_idle      = 1'b0;
    w_accept    = 1'b0;
    w_cnt_clr   = 1'b0;
    w_cnt_inc   = 1'b0;
    w_rsp_set   = 1'b0;
    w_rsp_err   = 1'b0;
    w_rsp_load  = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_idle = 1'b1;
        // Accepting here also covers the back-to-back case: the IDLE cycle
        // that carries rsp_valid_o can already take the next command.
        if (cmd_valid_i) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_SETUP;
        end
      end

      ST_SETUP: begin
        w_state_nxt = ST_ACCESS;
      end

      ST_ACCESS: begin
        // Completion is tested first so a late pready_i on the last budgeted
        // cycle still finishes the transfer instead of aborting it.
        if (pready_i) begin
          w_cnt_clr = 1'b1;
          if (!r_pwrite && RD_REG) begin
            w_state_nxt = ST_RDWAIT;
          end else begin
            w_state_nxt = ST_IDLE;
            w_rsp_set   = 1'b1;
            w_rsp_load  = !r_pwrite;
          end
        end else if (r_cnt == CNT_LAST) begin
          w_cnt_clr   = 1'b1;
          w_state_nxt = ST_IDLE;
          w_rsp_set   = 1'b1;
          w_rsp_err   = 1'b1;
        end else begin
          w_cnt_inc = 1'b1;
        end
      end

      ST_RDWAIT: begin
        w_state_nxt = ST_IDLE;
        w_rsp_set   = 1'b1;
        w_rsp_load  = 1'b1;
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // ------------------------------------------------------------------
  // State, command latch, wait counter and response registers
  // ------------------------------------------------------------------
  always_ff @(posedge pclk_i) begin
    if (!preset_ni) begin
      r_state     <= ST_IDLE;
      r_paddr     <= '0;
      r_pwdata    <= '0;
      r_pwrite    <= 1'b0;
      r_cnt       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_error <= 1'b0;
    end else begin
      r_state <= w_state_nxt;

      // Address/data/direction are only loaded on acceptance, so they stay
      // stable through SETUP/ACCESS and keep their last value in IDLE.
      if (w_accept) begin
        r_paddr  <= cmd_addr_i;
        r_pwdata <= cmd_wdata_i;
        r_pwrite <= cmd_write_i;
      end

      if (w_cnt_clr) begin
        r_cnt <= '0;
      end else if (w_cnt_inc && (r_cnt != CNT_SAT)) begin
        r_cnt <= r_cnt + CW'(1);
      end

      r_rsp_valid <= w_rsp_set;
      if (w_rsp_set) begin
        r_rsp_error <= w_rsp_err;
        // Writes and aborts return zero data.
        r_rsp_rdata <= w_rsp_load ? prdata_i : '0;
      end
    end
  end

  // ------------------------------------------------------------------
  // Outputs
  // ------------------------------------------------------------------
  // Select/enable decode straight from the state register, so a reset edge
  // mid-transfer drops them on that same edge.
  assign psel_o      = (r_state == ST_SETUP) || (r_state == ST_ACCESS);
  assign penable_o   = (r_state == ST_ACCESS);
  assign pwrite_o    = r_pwrite;
  assign paddr_o     = r_paddr;
  assign pwdata_o    = r_pwdata;

  // Held low while reset is asserted so that every output reads 0 in reset.
  assign cmd_ready_o = w_idle && preset_ni;

  assign rsp_valid_o = r_rsp_valid;
  assign rsp_rdata_o = r_rsp_rdata;
  assign rsp_error_o = r_rsp_error;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Purpose : directed bench for apb_master_bridge (TIMEOUT=4, READ_LAT=1) with a response scoreboard.
// Latency : inputs driven #1 after the rising edge, outputs sampled there or on the falling edge.
// Backpres: pready_i is driven directly by the directed sequence to create wait states and timeouts.
module tb_apb_master_bridge;

  localparam int DW = 8;
  localparam int AW = 8;

  logic          pclk_i = 1'b0;
  logic          preset_ni;
  logic          cmd_valid_i;
  logic          cmd_ready_o;
  logic          cmd_write_i;
  logic [AW-1:0] cmd_addr_i;
  logic [DW-1:0] cmd_wdata_i;
  logic          rsp_valid_o;
  logic [DW-1:0] rsp_rdata_o;
  logic          rsp_error_o;
  logic          psel_o;
  logic          penable_o;
  logic          pwrite_o;
  logic [AW-1:0] paddr_o;
  logic [DW-1:0] pwdata_o;
  logic [DW-1:0] prdata_i;
  logic          pready_i;

  int total = 0;
  int bad   = 0;

  // Expected responses: {error, rdata}
  logic [DW:0] exp_q[$];

  apb_master_bridge #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .READ_LAT  (1),
    .TIMEOUT   (4)
  ) dut (
    .pclk_i     (pclk_i),
    .preset_ni  (preset_ni),
    .cmd_valid_i(cmd_valid_i),
    .cmd_ready_o(cmd_ready_o),
    .cmd_write_i(cmd_write_i),
    .cmd_addr_i (cmd_addr_i),
    .cmd_wdata_i(cmd_wdata_i),
    .rsp_valid_o(rsp_valid_o),
    .rsp_rdata_o(rsp_rdata_o),
    .rsp_error_o(rsp_error_o),
    .psel_o     (psel_o),
    .penable_o  (penable_o),
    .pwrite_o   (pwrite_o),
    .paddr_o    (paddr_o),
    .pwdata_o   (pwdata_o),
    .prdata_i   (prdata_i),
    .pready_i   (pready_i)
  );

  always #5 pclk_i = ~pclk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge pclk_i);
    #1;
  endtask

  task automatic drive_cmd(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    cmd_valid_i = 1'b1;
    cmd_write_i = wr;
    cmd_addr_i  = a;
    cmd_wdata_i = d;
  endtask

  // Response monitor: every pulse must match the oldest expected response.
  always @(negedge pclk_i) begin
    if (preset_ni === 1'b1 && rsp_valid_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_rsp", 32'd1, 32'd0);
      end else begin
        logic [DW:0] e;
        e = exp_q.pop_front();
        chk("rsp_rdata", {24'd0, rsp_rdata_o}, {24'd0, e[DW-1:0]});
        chk("rsp_error", {31'd0, rsp_error_o}, {31'd0, e[DW]});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    preset_ni   = 1'b0;
    cmd_valid_i = 1'b0;
    cmd_write_i = 1'b0;
    cmd_addr_i  = '0;
    cmd_wdata_i = '0;
    prdata_i    = '0;
    pready_i    = 1'b1;

    // ---------------- reset state ----------------
    tick();
    tick();
    chk("rst_psel",      psel_o,      0);
    chk("rst_penable",   penable_o,   0);
    chk("rst_rsp_valid", rsp_valid_o, 0);
    chk("rst_paddr",     paddr_o,     0);
    chk("rst_pwdata",    pwdata_o,    0);
    chk("rst_rdata",     rsp_rdata_o, 0);
    chk("rst_error",     rsp_error_o, 0);
    chk("rst_ready",     cmd_ready_o, 0);
    preset_ni = 1'b1;
    tick();
    chk("idle_ready", cmd_ready_o, 1);

    // ---------------- write, zero wait ----------------
    drive_cmd(1'b1, 8'h14, 8'h3C);
    exp_q.push_back({1'b0, 8'h00});
    tick();
    cmd_valid_i = 1'b0;
    chk("wr_setup_psel",    psel_o,      1);
    chk("wr_setup_penable", penable_o,   0);
    chk("wr_setup_ready",   cmd_ready_o, 0);
    chk("wr_paddr",         paddr_o,     8'h14);
    chk("wr_pwdata",        pwdata_o,    8'h3C);
    chk("wr_pwrite",        pwrite_o,    1);
    tick();
    chk("wr_acc_psel",    psel_o,      1);
    chk("wr_acc_penable", penable_o,   1);
    chk("wr_acc_rspv",    rsp_valid_o, 0);
    tick();
    chk("wr_done_psel", psel_o,      0);
    chk("wr_done_rspv", rsp_valid_o, 1);
    chk("wr_done_addr", paddr_o,     8'h14);
    tick();
    chk("wr_rspv_1cyc", rsp_valid_o, 0);

    // ---------------- read, registered prdata ----------------
    drive_cmd(1'b0, 8'h0C, 8'h00);
    prdata_i = 8'hFF;   // stale value during ACCESS must not be captured
    exp_q.push_back({1'b0, 8'h5A});
    tick();
    cmd_valid_i = 1'b0;
    chk("rd_pwrite", pwrite_o, 0);
    chk("rd_paddr",  paddr_o,  8'h0C);
    tick();
    chk("rd_acc_penable", penable_o, 1);
    tick();
    chk("rd_wait_psel",    psel_o,      0);
    chk("rd_wait_penable", penable_o,   0);
    chk("rd_wait_rspv",    rsp_valid_o, 0);
    prdata_i = 8'h5A;
    tick();
    prdata_i = 8'h00;
    chk("rd_done_rspv",  rsp_valid_o, 1);
    chk("rd_done_rdata", rsp_rdata_o, 8'h5A);
    tick();

    // ---------------- read with 3 wait states (completes on last budgeted cycle) ----------------
    drive_cmd(1'b0, 8'h08, 8'h00);
    exp_q.push_back({1'b0, 8'hC3});
    tick();
    cmd_valid_i = 1'b0;
    pready_i    = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("ws_penable", penable_o, 1);
      chk("ws_paddr",   paddr_o,   8'h08);
      if (i == 3) pready_i = 1'b1;
    end
    tick();
    chk("ws_rdwait_penable", penable_o, 0);
    prdata_i = 8'hC3;
    tick();
    prdata_i = 8'h00;
    chk("ws_done_rspv", rsp_valid_o, 1);
    tick();
    chk("ws_rspv_1cyc", rsp_valid_o, 0);

    // ---------------- timeout, pready stuck low ----------------
    drive_cmd(1'b0, 8'h04, 8'h00);
    prdata_i = 8'h77;
    pready_i = 1'b0;
    exp_q.push_back({1'b1, 8'h00});
    tick();
    cmd_valid_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("to_penable", penable_o, 1);
    end
    tick();
    chk("to_psel",   psel_o,      0);
    chk("to_rspv",   rsp_valid_o, 1);
    chk("to_rdata",  rsp_rdata_o, 0);
    chk("to_ready",  cmd_ready_o, 1);
    prdata_i = 8'h00;
    pready_i = 1'b1;
    tick();

    // ---------------- back-to-back with ignored busy inputs ----------------
    drive_cmd(1'b1, 8'h00, 8'h11);
    exp_q.push_back({1'b0, 8'h00});
    tick();
    drive_cmd(1'b0, 8'h55, 8'hAA);   // must be ignored while busy
    chk("b2b_setup_addr", paddr_o, 8'h00);
    tick();
    drive_cmd(1'b1, 8'h10, 8'hE0);
    chk("b2b_acc_addr",  paddr_o,  8'h00);
    chk("b2b_acc_wdata", pwdata_o, 8'h11);
    chk("b2b_acc_write", pwrite_o, 1);
    tick();
    chk("b2b_rspv",  rsp_valid_o, 1);
    chk("b2b_ready", cmd_ready_o, 1);
    exp_q.push_back({1'b0, 8'h00});
    tick();
    cmd_valid_i = 1'b0;
    chk("b2b2_psel",    psel_o,    1);
    chk("b2b2_penable", penable_o, 0);
    chk("b2b2_addr",    paddr_o,   8'h10);
    chk("b2b2_wdata",   pwdata_o,  8'hE0);
    tick();
    tick();
    chk("b2b2_rspv", rsp_valid_o, 1);
    tick();

    // ---------------- reset mid-ACCESS ----------------
    drive_cmd(1'b1, 8'h20, 8'h99);
    pready_i = 1'b0;
    tick();
    cmd_valid_i = 1'b0;
    tick();
    chk("mr_acc_penable", penable_o, 1);
    preset_ni = 1'b0;
    tick();
    chk("mr_psel",    psel_o,      0);
    chk("mr_penable", penable_o,   0);
    chk("mr_rspv",    rsp_valid_o, 0);
    chk("mr_paddr",   paddr_o,     0);
    preset_ni = 1'b1;
    pready_i  = 1'b1;
    tick();
    chk("mr_ready", cmd_ready_o, 1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("mr_no_rsp", rsp_valid_o, 0);
    end

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
